// File: rtl/reorder_buffer_pkg.sv
// Shared widths and sentinels for the ROB, rename regfile and reservation stations.
package reorder_buffer_pkg;
    localparam int ROB_IDX_LN = 4;
    localparam int ROB_SIZE   = 1 << ROB_IDX_LN;
    localparam int WORD_LN    = 32;
    localparam int REG_IDX_LN = 5;

    typedef logic [ROB_IDX_LN-1:0] rob_idx_t;
    typedef logic [WORD_LN-1:0]    word_t;
    typedef logic [REG_IDX_LN-1:0] reg_idx_t;

    localparam rob_idx_t ZERO_ROB_IDX = '0;
    localparam word_t    ZERO_WORD    = '0;
endpackage

// File: rtl/reorder_buffer_ptr_inc.sv
// Circular ROB pointer increment; tag 0 is reserved, so the pointer wraps to 1.
module rob_ptr_inc
#(
    parameter int ROB_BIT = 4
)(
    input  logic [ROB_BIT-1:0] ptr,
    output logic [ROB_BIT-1:0] nxt
);
    localparam logic [ROB_BIT-1:0] LAST = {ROB_BIT{1'b1}};
    localparam logic [ROB_BIT-1:0] ONE  = {{(ROB_BIT-1){1'b0}}, 1'b1};

    assign nxt = (ptr == LAST) ? ONE : ptr + ONE;
endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement queue: allocates tags, captures CDB results, retires the head
// to the regfile and raises a rollback on a mispredicted head branch.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_BIT  = ROB_IDX_LN,
    parameter int ROB_SIZE = 1 << ROB_BIT
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,

    input  logic                  id_alloc_ena,
    input  logic [REG_IDX_LN-1:0] id_alloc_rd,
    input  logic                  id_alloc_br,
    input  logic                  id_alloc_pred,
    output logic [ROB_BIT-1:0]    id_alloc_idx,
    output logic                  rob_full,

    input  logic [ROB_BIT-1:0]    id_q1_idx,
    input  logic [ROB_BIT-1:0]    id_q2_idx,
    output logic                  id_q1_rdy,
    output logic                  id_q2_rdy,
    output logic [WORD_LN-1:0]    id_q1_val,
    output logic [WORD_LN-1:0]    id_q2_val,

    input  logic                  cdb_ena,
    input  logic [ROB_BIT-1:0]    cdb_idx,
    input  logic [WORD_LN-1:0]    cdb_val,
    input  logic                  cdb_taken,
    input  logic [WORD_LN-1:0]    cdb_target,

    output logic                  rob_wr_ena,
    output logic [REG_IDX_LN-1:0] rob_wr_rd,
    output logic [WORD_LN-1:0]    rob_wr_val,
    output logic [ROB_BIT-1:0]    rob_wr_idx,

    output logic                  reg_rb,
    output logic [WORD_LN-1:0]    rb_pc
);
    localparam logic [ROB_BIT-1:0] PTR_ONE = {{(ROB_BIT-1){1'b0}}, 1'b1};
    localparam logic [ROB_BIT-1:0] CAP     = {ROB_BIT{1'b1}};

    logic                  valid_q  [ROB_SIZE];
    logic                  ready_q  [ROB_SIZE];
    logic [REG_IDX_LN-1:0] rd_q     [ROB_SIZE];
    logic [WORD_LN-1:0]    val_q    [ROB_SIZE];
    logic                  br_q     [ROB_SIZE];
    logic                  pred_q   [ROB_SIZE];
    logic                  taken_q  [ROB_SIZE];
    logic [WORD_LN-1:0]    target_q [ROB_SIZE];

    logic [ROB_BIT-1:0] head, tail, count;
    logic [ROB_BIT-1:0] head_nxt, tail_nxt;
    logic               commit, mispredict, alloc_fire, cdb_fire;

    rob_ptr_inc #(.ROB_BIT(ROB_BIT)) u_head_inc (.ptr(head), .nxt(head_nxt));
    rob_ptr_inc #(.ROB_BIT(ROB_BIT)) u_tail_inc (.ptr(tail), .nxt(tail_nxt));

    assign id_alloc_idx = tail;
    assign rob_full     = (count == CAP);

    // Commit is gated by rst so nothing retires in the cycle reset is applied.
    assign commit     = rst && rdy && (count != '0) && ready_q[head];
    assign mispredict = commit && br_q[head] && (taken_q[head] != pred_q[head]);
    assign alloc_fire = id_alloc_ena && !rob_full && !mispredict;
    assign cdb_fire   = cdb_ena && (cdb_idx != '0) && valid_q[cdb_idx] && !mispredict;

    assign rob_wr_ena = commit && (rd_q[head] != '0);
    assign rob_wr_rd  = commit ? rd_q[head]  : '0;
    assign rob_wr_val = commit ? val_q[head] : ZERO_WORD;
    assign rob_wr_idx = commit ? head        : '0;
    assign reg_rb     = mispredict;
    assign rb_pc      = mispredict ? target_q[head] : ZERO_WORD;

    // Same-cycle CDB bypass wins over the stored value.
    function automatic logic q_rdy(input logic [ROB_BIT-1:0] tag);
        if (tag == '0)                        return 1'b1;
        else if (cdb_ena && cdb_idx == tag)   return 1'b1;
        else                                  return ready_q[tag];
    endfunction

    function automatic logic [WORD_LN-1:0] q_val(input logic [ROB_BIT-1:0] tag);
        if (tag == '0)                        return ZERO_WORD;
        else if (cdb_ena && cdb_idx == tag)   return cdb_val;
        else if (ready_q[tag])                return val_q[tag];
        else                                  return ZERO_WORD;
    endfunction

    assign id_q1_rdy = q_rdy(id_q1_idx);
    assign id_q2_rdy = q_rdy(id_q2_idx);
    assign id_q1_val = q_val(id_q1_idx);
    assign id_q2_val = q_val(id_q2_idx);

    always_ff @(posedge clk) begin
        if (!rst) begin
            head  <= PTR_ONE;
            tail  <= PTR_ONE;
            count <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                valid_q[i] <= 1'b0;
                ready_q[i] <= 1'b0;
            end
        end else if (rdy) begin
            if (mispredict) begin
                head  <= PTR_ONE;
                tail  <= PTR_ONE;
                count <= '0;
                for (int i = 0; i < ROB_SIZE; i++) begin
                    valid_q[i] <= 1'b0;
                    ready_q[i] <= 1'b0;
                end
            end else begin
                if (alloc_fire) begin
                    valid_q[tail] <= 1'b1;
                    ready_q[tail] <= 1'b0;
                    rd_q[tail]    <= id_alloc_rd;
                    br_q[tail]    <= id_alloc_br;
                    pred_q[tail]  <= id_alloc_pred;
                    tail          <= tail_nxt;
                end
                if (cdb_fire) begin
                    ready_q[cdb_idx]  <= 1'b1;
                    val_q[cdb_idx]    <= cdb_val;
                    taken_q[cdb_idx]  <= cdb_taken;
                    target_q[cdb_idx] <= cdb_target;
                end
                if (commit) begin
                    valid_q[head] <= 1'b0;
                    ready_q[head] <= 1'b0;
                    head          <= head_nxt;
                end
                if (alloc_fire && !commit)      count <= count + PTR_ONE;
                else if (!alloc_fire && commit) count <= count - PTR_ONE;
            end
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer with hand-computed expectations.
module tb_reorder_buffer;
    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        id_alloc_ena, id_alloc_br, id_alloc_pred;
    logic [4:0]  id_alloc_rd;
    logic [3:0]  id_alloc_idx;
    logic        rob_full;
    logic [3:0]  id_q1_idx, id_q2_idx;
    logic        id_q1_rdy, id_q2_rdy;
    logic [31:0] id_q1_val, id_q2_val;
    logic        cdb_ena, cdb_taken;
    logic [3:0]  cdb_idx;
    logic [31:0] cdb_val, cdb_target;
    logic        rob_wr_ena;
    logic [4:0]  rob_wr_rd;
    logic [31:0] rob_wr_val;
    logic [3:0]  rob_wr_idx;
    logic        reg_rb;
    logic [31:0] rb_pc;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    reorder_buffer dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .id_alloc_ena(id_alloc_ena), .id_alloc_rd(id_alloc_rd), .id_alloc_br(id_alloc_br),
        .id_alloc_pred(id_alloc_pred), .id_alloc_idx(id_alloc_idx), .rob_full(rob_full),
        .id_q1_idx(id_q1_idx), .id_q2_idx(id_q2_idx), .id_q1_rdy(id_q1_rdy), .id_q2_rdy(id_q2_rdy),
        .id_q1_val(id_q1_val), .id_q2_val(id_q2_val),
        .cdb_ena(cdb_ena), .cdb_idx(cdb_idx), .cdb_val(cdb_val), .cdb_taken(cdb_taken),
        .cdb_target(cdb_target),
        .rob_wr_ena(rob_wr_ena), .rob_wr_rd(rob_wr_rd), .rob_wr_val(rob_wr_val),
        .rob_wr_idx(rob_wr_idx), .reg_rb(reg_rb), .rb_pc(rb_pc)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Leaves time at posedge+2; callers drive inputs and settle with #1 before checking.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        id_alloc_ena = 0; id_alloc_rd = 0; id_alloc_br = 0; id_alloc_pred = 0;
        cdb_ena = 0; cdb_idx = 0; cdb_val = 0; cdb_taken = 0; cdb_target = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 0;
        cyc();
        cyc();
        rst = 1;
        #1;
    endtask

    task automatic alloc(input logic [4:0] rd, input logic br, input logic pred);
        id_alloc_ena = 1; id_alloc_rd = rd; id_alloc_br = br; id_alloc_pred = pred;
        cyc();
        idle();
        #1;
    endtask

    task automatic cdb(input logic [3:0] idx, input logic [31:0] val,
                       input logic taken, input logic [31:0] target);
        cdb_ena = 1; cdb_idx = idx; cdb_val = val; cdb_taken = taken; cdb_target = target;
        cyc();
        idle();
        #1;
    endtask

    initial begin
        rst = 0; rdy = 1; id_q1_idx = 0; id_q2_idx = 0;
        idle();

        // 1. reset
        do_reset();
        chk("rst_alloc_idx", id_alloc_idx, 1);
        chk("rst_full", rob_full, 0);
        chk("rst_wr_ena", rob_wr_ena, 0);
        chk("rst_rb", reg_rb, 0);
        chk("rst_rb_pc", rb_pc, 0);
        chk("rst_wr_val", rob_wr_val, 0);

        // 2. single alloc / complete / retire
        alloc(5'd5, 0, 0);
        chk("t2_alloc_idx", id_alloc_idx, 2);
        chk("t2_no_early_commit", rob_wr_ena, 0);
        cdb(4'd1, 32'h2A, 0, 0);
        chk("t2_wr_ena", rob_wr_ena, 1);
        chk("t2_wr_rd", rob_wr_rd, 5);
        chk("t2_wr_val", rob_wr_val, 32'h2A);
        chk("t2_wr_idx", rob_wr_idx, 1);
        cyc(); #1;
        chk("t2_empty_wr_ena", rob_wr_ena, 0);
        chk("t2_empty_full", rob_full, 0);

        // 3. fill, overflow drop, out-of-order completion, in-order retire
        do_reset();
        for (int i = 1; i <= 15; i++) begin
            chk($sformatf("t3_tag%0d", i), id_alloc_idx, i);
            chk($sformatf("t3_notfull%0d", i), rob_full, 0);
            alloc(5'(i), 0, 0);
        end
        chk("t3_wrap_idx", id_alloc_idx, 1);
        chk("t3_full", rob_full, 1);
        alloc(5'd31, 0, 0);
        chk("t3_drop_idx", id_alloc_idx, 1);
        chk("t3_drop_full", rob_full, 1);
        for (int i = 15; i >= 2; i--) begin
            cdb(4'(i), 32'h100 + i, 0, 0);
            chk($sformatf("t3_hold%0d", i), rob_wr_ena, 0);
        end
        cdb(4'd1, 32'h101, 0, 0);
        for (int k = 1; k <= 15; k++) begin
            chk($sformatf("t3_ena%0d", k), rob_wr_ena, 1);
            chk($sformatf("t3_idx%0d", k), rob_wr_idx, k);
            chk($sformatf("t3_rd%0d", k), rob_wr_rd, k);
            chk($sformatf("t3_val%0d", k), rob_wr_val, 32'h100 + k);
            cyc(); #1;
        end
        chk("t3_drained", rob_wr_ena, 0);
        chk("t3_drained_full", rob_full, 0);
        chk("t3_drained_idx", id_alloc_idx, 1);

        // 4. mispredicted head branch flushes younger ready entries
        do_reset();
        alloc(5'd3, 1, 0);
        alloc(5'd4, 0, 0);
        alloc(5'd6, 0, 0);
        cdb(4'd3, 32'd3, 0, 0);
        cdb(4'd2, 32'd2, 0, 0);
        chk("t4_wait", rob_wr_ena, 0);
        cdb(4'd1, 32'h55, 1, 32'h1000);
        chk("t4_rb", reg_rb, 1);
        chk("t4_rb_pc", rb_pc, 32'h1000);
        chk("t4_wr_ena", rob_wr_ena, 1);
        chk("t4_wr_idx", rob_wr_idx, 1);
        chk("t4_wr_val", rob_wr_val, 32'h55);
        cyc(); #1;
        chk("t4_rb_once", reg_rb, 0);
        chk("t4_no_t2", rob_wr_ena, 0);
        chk("t4_alloc_idx", id_alloc_idx, 1);
        cyc(); #1;
        chk("t4_no_t3", rob_wr_ena, 0);
        alloc(5'd7, 0, 0);
        chk("t4_realloc", id_alloc_idx, 2);

        // 5. query bypass, rd=0 retire
        do_reset();
        alloc(5'd0, 0, 0);
        alloc(5'd8, 0, 0);
        alloc(5'd9, 0, 0);
        id_q1_idx = 3; id_q2_idx = 0;
        #1;
        chk("t5_q1_pend_rdy", id_q1_rdy, 0);
        chk("t5_q1_pend_val", id_q1_val, 0);
        chk("t5_q2_zero_rdy", id_q2_rdy, 1);
        chk("t5_q2_zero_val", id_q2_val, 0);
        cdb_ena = 1; cdb_idx = 3; cdb_val = 7;
        #1;
        chk("t5_bypass_rdy", id_q1_rdy, 1);
        chk("t5_bypass_val", id_q1_val, 7);
        cyc(); idle(); #1;
        chk("t5_stored_rdy", id_q1_rdy, 1);
        chk("t5_stored_val", id_q1_val, 7);
        cdb(4'd1, 32'h99, 0, 0);
        chk("t5_rd0_ena", rob_wr_ena, 0);
        chk("t5_rd0_idx", rob_wr_idx, 1);
        chk("t5_rd0_rb", reg_rb, 0);
        cyc(); #1;
        chk("t5_head2_wait", rob_wr_ena, 0);

        // 6. rdy=0 freezes a ready head
        cdb(4'd2, 32'h22, 0, 0);
        rdy = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("t6_frz_ena%0d", i), rob_wr_ena, 0);
            chk($sformatf("t6_frz_idx%0d", i), id_alloc_idx, 4);
            cyc();
        end
        rdy = 1;
        #1;
        chk("t6_ena", rob_wr_ena, 1);
        chk("t6_idx", rob_wr_idx, 2);
        chk("t6_val", rob_wr_val, 32'h22);
        cyc(); #1;
        chk("t6_next_idx", rob_wr_idx, 3);
        chk("t6_next_rd", rob_wr_rd, 9);
        chk("t6_next_val", rob_wr_val, 7);
        cyc(); #1;
        chk("t6_empty", rob_wr_ena, 0);

        // reset with a ready head: no commit in the reset cycle, entries discarded
        alloc(5'd12, 0, 0);
        cdb(4'd4, 32'h44, 0, 0);
        chk("rst2_pre", rob_wr_ena, 1);
        rst = 0;
        #1;
        chk("rst2_no_commit", rob_wr_ena, 0);
        cyc();
        rst = 1;
        #1;
        chk("rst2_idx", id_alloc_idx, 1);
        chk("rst2_gone", rob_wr_ena, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
